fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 37 +++
 rtl/fifo.sv | 103 ++++++++++
 tb/tb_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the pointer-width helper.
package fifo_pkg;

    localparam int FIFO_DEFAULT_DATA_WIDTH = 4;
    localparam int FIFO_DEFAULT_DEPTH      = 8;

    // One extra pointer bit tells a full FIFO apart from an empty one.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and a registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEFAULT_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are intentionally left alone by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: loads the addressed word on an accepted pop, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO: pointer, flag and control logic around fifo_mem.
// Optional sticky overflow/underflow outputs are enabled by FIFO_ERR_FLAGS_EN.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_W  = fifo_ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_nxt_s;
    logic             empty_nxt_s;

    // When full, a simultaneous pop frees the slot the push then reuses.
    assign push_ok_s = push && (!fifo_full || pop);
    assign pop_ok_s  = pop && !fifo_empty;

    // Next-pointer computation and the full/empty decode of the next state.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]) &&
                      (wr_ptr_nxt_s[PTR_W-1] != rd_ptr_nxt_s[PTR_W-1]);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            fifo_empty <= empty_nxt_s;
            fifo_full  <= full_nxt_s;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  || (push && !push_ok_s);
            underflow <= underflow || (pop && !pop_ok_s);
        end
    end
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok_s),
        .wr_addr (wr_ptr_r[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (pop_ok_s),
        .rd_addr (rd_ptr_r[ADDR_W-1:0]),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (DATA_WIDTH=4, DEPTH=8).
module tb_fifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       fifo_full;
    logic       fifo_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int total_cnt  = 0;
    int passed_cnt = 0;
    int failed_cnt = 0;

    fifo #(.DATA_WIDTH(4), .DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            passed_cnt++;
        end else begin
            failed_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given request; outputs are sampled 1 ns after the edge.
    task automatic step(input logic p, input logic q, input logic [3:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 4'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_data_out", data_out, 0);
        check("reset_empty", fifo_empty, 1);
        check("reset_full", fifo_full, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("reset_overflow", overflow, 0);
        check("reset_underflow", underflow, 0);
`endif

        // Basic order: push 3,2,4,5 then pop four times.
        step(1'b1, 1'b0, 4'd3);
        check("first_push_empty", fifo_empty, 0);
        check("first_push_data_out_holds", data_out, 0);
        step(1'b1, 1'b0, 4'd2);
        step(1'b1, 1'b0, 4'd4);
        step(1'b1, 1'b0, 4'd5);
        check("four_held_full", fifo_full, 0);
        step(1'b0, 1'b1, 4'd0);
        check("pop1", data_out, 3);
        step(1'b0, 1'b1, 4'd0);
        check("pop2", data_out, 2);
        step(1'b0, 1'b1, 4'd0);
        check("pop3", data_out, 4);
        check("pop3_not_empty", fifo_empty, 0);
        step(1'b0, 1'b1, 4'd0);
        check("pop4", data_out, 5);
        check("drained_empty", fifo_empty, 1);

        // Pop while empty is ignored.
        step(1'b0, 1'b1, 4'd0);
        check("underrun_data_out", data_out, 5);
        check("underrun_empty", fifo_empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
        check("underflow_set", underflow, 1);
        check("underflow_no_overflow", overflow, 0);
`endif

        // Fill to full (wrapping pointers), reject a 9th push, then drain.
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 4'(i));
        check("seven_not_full", fifo_full, 0);
        step(1'b1, 1'b0, 4'd8);
        check("eight_full", fifo_full, 1);
        check("eight_not_empty", fifo_empty, 0);
        step(1'b1, 1'b0, 4'd9);
        check("ninth_full", fifo_full, 1);
        check("ninth_data_out_holds", data_out, 5);
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow_set", overflow, 1);
`endif
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 4'd0);
            check($sformatf("drain_%0d", i), data_out, i);
            check($sformatf("drain_full_%0d", i), fifo_full, 0);
        end
        check("drain_empty", fifo_empty, 1);

        // Repeated 7,5 traffic across wrap-around.
        for (int r = 0; r < 6; r++) begin
            step(1'b1, 1'b0, 4'd7);
            step(1'b1, 1'b0, 4'd5);
            step(1'b0, 1'b1, 4'd0);
            check($sformatf("wrap_%0d_a", r), data_out, 7);
            step(1'b0, 1'b1, 4'd0);
            check($sformatf("wrap_%0d_b", r), data_out, 5);
            check($sformatf("wrap_%0d_empty", r), fifo_empty, 1);
        end

        // Simultaneous push/pop with 3 entries held.
        step(1'b1, 1'b0, 4'd1);
        step(1'b1, 1'b0, 4'd2);
        step(1'b1, 1'b0, 4'd3);
        step(1'b1, 1'b1, 4'd6);
        check("pp_oldest_out", data_out, 1);
        check("pp_not_empty", fifo_empty, 0);
        check("pp_not_full", fifo_full, 0);
        step(1'b0, 1'b1, 4'd0);
        check("pp_pop_a", data_out, 2);
        step(1'b0, 1'b1, 4'd0);
        check("pp_pop_b", data_out, 3);
        step(1'b0, 1'b1, 4'd0);
        check("pp_pop_c", data_out, 6);
        check("pp_drained_empty", fifo_empty, 1);

        // Simultaneous push/pop while empty: only the push happens.
        step(1'b1, 1'b0, 4'd4);
        step(1'b0, 1'b1, 4'd0);
        check("pre_empty_pp_out", data_out, 4);
        step(1'b1, 1'b1, 4'd6);
        check("empty_pp_data_out_holds", data_out, 4);
        check("empty_pp_not_empty", fifo_empty, 0);
        step(1'b0, 1'b1, 4'd0);
        check("empty_pp_stored", data_out, 6);
        check("empty_pp_then_empty", fifo_empty, 1);

        // Reset with 4 entries held, and with push/pop also requested.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 4'(i + 8));
        reset = 1'b1;
        step(1'b1, 1'b1, 4'd15);
        reset = 1'b0;
        check("midreset_data_out", data_out, 0);
        check("midreset_empty", fifo_empty, 1);
        check("midreset_full", fifo_full, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("midreset_overflow", overflow, 0);
        check("midreset_underflow", underflow, 0);
`endif
        step(1'b0, 1'b1, 4'd0);
        check("post_reset_pop_data_out", data_out, 0);
        check("post_reset_pop_empty", fifo_empty, 1);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
